// File: rtl/hazard_pkg.sv
// Shared latency encoding for the hazard scoreboard and the decoder that drives id_lat.
package hazard_pkg;

  localparam int HZ_LAT_W = 4;

  typedef logic [HZ_LAT_W-1:0] lat_t;

  // All-ones latency code marks a variable-latency (long unit) result.
  function automatic int lat_long_of(input int w);
    return (1 << w) - 1;
  endfunction

  localparam lat_t LAT_LONG = lat_t'(lat_long_of(HZ_LAT_W));
  localparam lat_t LAT_ALU  = lat_t'(0);
  localparam lat_t LAT_LOAD = lat_t'(1);

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module hazard_sat_counter
  import hazard_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [PERF_W-1:0] value
);

  // Holds at all-ones instead of wrapping so long runs never read as small counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + PERF_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard: stalls ID on unresolved sources or a busy long unit,
// flushes on taken branches, and counts stall/flush cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int NUM_SRC  = 2,
  parameter  int LAT_W    = 4,
  parameter  int FWD_EN   = 1,
  parameter  int WB_DIST  = 3,
  parameter  int PERF_W   = 32,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [NUM_SRC-1:0]      id_src_valid,
  input  logic [NUM_SRC*RA_W-1:0] id_src,
  input  logic                    id_reg_write,
  input  logic [RA_W-1:0]         id_rd,
  input  logic [LAT_W-1:0]        id_lat,
  input  logic                    branch_taken_ex,
  input  logic                    long_done,
  input  logic [RA_W-1:0]         long_rd,
  output logic                    stall_pc,
  output logic                    stall_if_id,
  output logic                    flush_if_id,
  output logic                    flush_id_ex,
  output logic                    long_busy,
  output logic                    long_err,
  output logic [PERF_W-1:0]       perf_stall,
  output logic [PERF_W-1:0]       perf_flush
);

  localparam logic [LAT_W-1:0] LONG   = LAT_W'(lat_long_of(LAT_W));
  localparam logic [LAT_W-1:0] WB_LAT = (WB_DIST >= lat_long_of(LAT_W)) ?
                                        LAT_W'(lat_long_of(LAT_W) - 1) : LAT_W'(WB_DIST);

  logic [LAT_W-1:0]   cnt [NUM_REGS];
  logic [NUM_SRC-1:0] src_busy;
  logic [LAT_W-1:0]   eff_lat;
  logic               raw_haz;
  logic               struct_haz;
  logic               stall;
  logic               issue;
  logic               long_clear;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [RA_W-1:0] addr;
    assign addr        = id_src[i*RA_W +: RA_W];
    assign src_busy[i] = id_src_valid[i] & (addr != '0) & (cnt[addr] != '0);
  end

  assign raw_haz    = id_valid & (|src_busy);
  assign struct_haz = id_valid & (id_lat == LONG) & long_busy & ~long_done;
  assign stall      = (raw_haz | struct_haz) & ~branch_taken_ex;
  assign issue      = id_valid & ~stall & ~branch_taken_ex;
  // A completion with nothing outstanding is an error and must not touch the scoreboard.
  assign long_clear = long_done & long_busy;

  // Without forwarding a consumer must wait until the register file has the value.
  always_comb begin
    eff_lat = id_lat;
    if (id_lat != LONG && FWD_EN == 0) begin
      eff_lat = (id_lat > WB_LAT) ? id_lat : WB_LAT;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_live
      logic [LAT_W-1:0] cnt_q;
      logic             wr_hit;
      logic             done_hit;

      assign wr_hit   = issue & id_reg_write & (id_rd == RA_W'(r));
      assign done_hit = long_clear & (long_rd == RA_W'(r)) & (cnt_q == LONG);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else if (wr_hit) begin
          cnt_q <= eff_lat;
        end else if (done_hit) begin
          cnt_q <= '0;
        end else if (cnt_q != '0 && cnt_q != LONG) begin
          cnt_q <= cnt_q - LAT_W'(1);
        end
      end

      assign cnt[r] = cnt_q;
    end
  end

  // Issuing a new long op wins over a completion in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      long_busy <= 1'b0;
    end else if (issue && id_lat == LONG) begin
      long_busy <= 1'b1;
    end else if (long_done) begin
      long_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      long_err <= 1'b0;
    end else if (long_done && !long_busy) begin
      long_err <= 1'b1;
    end
  end

  assign stall_pc    = stall;
  assign stall_if_id = stall;
  assign flush_if_id = branch_taken_ex;
  assign flush_id_ex = stall | branch_taken_ex;

  hazard_sat_counter #(.PERF_W(PERF_W)) u_perf_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .value (perf_stall)
  );

  hazard_sat_counter #(.PERF_W(PERF_W)) u_perf_flush (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_taken_ex),
    .value (perf_flush)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives a forwarding scoreboard and a no-forwarding, narrow-counter scoreboard with
// the same instruction stream and compares both against a ready-time reference model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam logic [3:0] LONG = 4'hF;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [1:0] id_src_valid;
  logic [9:0] id_src;
  logic       id_reg_write;
  logic [4:0] id_rd;
  logic [3:0] id_lat;
  logic       branch_taken_ex;
  logic       long_done;
  logic [4:0] long_rd;

  logic        stall_pc0, stall_if_id0, flush_if_id0, flush_id_ex0, long_busy0, long_err0;
  logic [31:0] perf_stall0, perf_flush0;
  logic        stall_pc1, stall_if_id1, flush_if_id1, flush_id_ex1, long_busy1, long_err1;
  logic [3:0]  perf_stall1, perf_flush1;

  int checks = 0;
  int errors = 0;

  // Reference model: a register is ready from cycle ready_at on, unless a long op is pending.
  longint cyc;
  longint ready_at [2][32];
  bit     pend     [2][32];
  bit     busy     [2];
  bit     err      [2];
  longint pstall   [2];
  longint pflush   [2];

  int last_stall0, last_stall1, last_fide0, last_fifd0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.FWD_EN(1), .PERF_W(32)) dut_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_valid(id_src_valid),
    .id_src(id_src), .id_reg_write(id_reg_write), .id_rd(id_rd), .id_lat(id_lat),
    .branch_taken_ex(branch_taken_ex), .long_done(long_done), .long_rd(long_rd),
    .stall_pc(stall_pc0), .stall_if_id(stall_if_id0), .flush_if_id(flush_if_id0),
    .flush_id_ex(flush_id_ex0), .long_busy(long_busy0), .long_err(long_err0),
    .perf_stall(perf_stall0), .perf_flush(perf_flush0)
  );

  hazard_scoreboard #(.FWD_EN(0), .PERF_W(4)) dut_nofwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_valid(id_src_valid),
    .id_src(id_src), .id_reg_write(id_reg_write), .id_rd(id_rd), .id_lat(id_lat),
    .branch_taken_ex(branch_taken_ex), .long_done(long_done), .long_rd(long_rd),
    .stall_pc(stall_pc1), .stall_if_id(stall_if_id1), .flush_if_id(flush_if_id1),
    .flush_id_ex(flush_id_ex1), .long_busy(long_busy1), .long_err(long_err1),
    .perf_stall(perf_stall1), .perf_flush(perf_flush1)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input longint v, input int w);
    longint m = (longint'(1) << w) - 1;
    return int'((v > m) ? m : v);
  endfunction

  function automatic bit expStall(input int c);
    bit raw = 1'b0;
    bit strct;
    for (int i = 0; i < 2; i++) begin
      int a = int'(id_src[i*5 +: 5]);
      if (id_src_valid[i] && a != 0 && (pend[c][a] || ready_at[c][a] > cyc)) raw = 1'b1;
    end
    strct = id_valid && (id_lat == LONG) && busy[c] && !long_done;
    return ((id_valid && raw) || strct) && !branch_taken_ex;
  endfunction

  task automatic resetModel();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 32; r++) begin
        ready_at[c][r] = 0;
        pend[c][r]     = 1'b0;
      end
      busy[c]   = 1'b0;
      err[c]    = 1'b0;
      pstall[c] = 0;
      pflush[c] = 0;
    end
  endtask

  task automatic modelEdge();
    for (int c = 0; c < 2; c++) begin
      bit st  = expStall(c);
      bit iss = id_valid && !st && !branch_taken_ex;
      int lr  = int'(long_rd);
      int rd  = int'(id_rd);
      int lat = int'(id_lat);
      if (long_done) begin
        if (!busy[c]) err[c] = 1'b1;
        else if (pend[c][lr]) begin
          pend[c][lr]     = 1'b0;
          ready_at[c][lr] = cyc + 1;
        end
      end
      if (iss && id_reg_write && rd != 0) begin
        if (id_lat == LONG) pend[c][rd] = 1'b1;
        else begin
          int eff = (c == 0) ? lat : ((lat > 3) ? lat : 3);
          pend[c][rd]     = 1'b0;
          ready_at[c][rd] = cyc + 1 + eff;
        end
      end
      if (iss && id_lat == LONG) busy[c] = 1'b1;
      else if (long_done)        busy[c] = 1'b0;
      pstall[c] += longint'(st);
      pflush[c] += longint'(branch_taken_ex);
    end
    cyc++;
  endtask

  task automatic checkAll();
    string nm [8] = '{"stall_pc", "stall_if_id", "flush_if_id", "flush_id_ex",
                      "long_busy", "long_err", "perf_stall", "perf_flush"};
    for (int c = 0; c < 2; c++) begin
      int o [8];
      int e [8];
      int st = int'(expStall(c));
      int br = int'(branch_taken_ex);
      int w  = (c == 0) ? 32 : 4;
      if (c == 0)
        o = '{int'(stall_pc0), int'(stall_if_id0), int'(flush_if_id0), int'(flush_id_ex0),
              int'(long_busy0), int'(long_err0), int'(perf_stall0), int'(perf_flush0)};
      else
        o = '{int'(stall_pc1), int'(stall_if_id1), int'(flush_if_id1), int'(flush_id_ex1),
              int'(long_busy1), int'(long_err1), int'(perf_stall1), int'(perf_flush1)};
      e = '{st, st, br, st | br, int'(busy[c]), int'(err[c]), sat(pstall[c], w), sat(pflush[c], w)};
      for (int k = 0; k < 8; k++)
        checkOutput($sformatf("dut%0d %s @%0d", c, nm[k], cyc), o[k], e[k]);
    end
  endtask

  // One ID cycle: drive at the falling edge, compare mid-phase, then let the rising edge commit.
  task automatic applyStimulus(input int v, input int sv, input int s0, input int s1,
                               input int wr, input int rd, input int lat, input int br,
                               input int ld, input int lrd);
    id_valid        = v[0];
    id_src_valid    = sv[1:0];
    id_src          = {s1[4:0], s0[4:0]};
    id_reg_write    = wr[0];
    id_rd           = rd[4:0];
    id_lat          = lat[3:0];
    branch_taken_ex = br[0];
    long_done       = ld[0];
    long_rd         = lrd[4:0];
    #2;
    checkAll();
    last_stall0 = int'(stall_pc0);
    last_stall1 = int'(stall_pc1);
    last_fide0  = int'(flush_id_ex0);
    last_fifd0  = int'(flush_if_id0);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n0, n1;
    cyc = 0;
    resetModel();
    reset = 1'b0;
    id_valid = 1'b0; id_src_valid = '0; id_src = '0; id_reg_write = 1'b0; id_rd = '0;
    id_lat = '0; branch_taken_ex = 1'b0; long_done = 1'b0; long_rd = '0;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset stall_pc", int'(stall_pc0), 0);
    checkOutput("reset flush_id_ex", int'(flush_id_ex0), 0);
    checkOutput("reset long_busy", int'(long_busy0), 0);
    checkOutput("reset long_err", int'(long_err0), 0);
    checkOutput("reset perf_stall", int'(perf_stall0), 0);
    checkOutput("reset perf_flush1", int'(perf_flush1), 0);
    @(negedge clk);
    reset = 1'b1;

    // Load x5 then a dependent add: exactly one bubble with forwarding.
    applyStimulus(1, 0, 0, 0, 1, 5, int'(LAT_LOAD), 0, 0, 0);
    applyStimulus(1, 3, 5, 1, 1, 6, int'(LAT_ALU), 0, 0, 0);
    checkOutput("loaduse stall", last_stall0, 1);
    checkOutput("loaduse flush_id_ex", last_fide0, 1);
    applyStimulus(1, 3, 5, 1, 1, 6, int'(LAT_ALU), 0, 0, 0);
    checkOutput("loaduse released", last_stall0, 0);
    checkOutput("loaduse perf_stall", int'(perf_stall0), 1);
    nop(4);

    // ALU result without forwarding waits for write-back; x0 never blocks.
    applyStimulus(1, 0, 0, 0, 1, 7, int'(LAT_ALU), 0, 0, 0);
    n0 = 0; n1 = 0;
    repeat (4) begin
      applyStimulus(1, 1, 7, 0, 0, 0, int'(LAT_ALU), 0, 0, 0);
      n0 += last_stall0; n1 += last_stall1;
    end
    checkOutput("nofwd alu stalls", n1, 3);
    checkOutput("fwd alu stalls", n0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, int'(LAT_ALU), 0, 0, 0);
    n0 = 0; n1 = 0;
    repeat (2) begin
      applyStimulus(1, 3, 0, 0, 0, 0, int'(LAT_ALU), 0, 0, 0);
      n0 += last_stall0; n1 += last_stall1;
    end
    checkOutput("x0 stalls", n0 + n1, 0);
    nop(4);

    // Divide into x8: consumer and a second divide wait for completion.
    applyStimulus(1, 0, 0, 0, 1, 8, 15, 0, 0, 0);
    checkOutput("div busy", int'(long_busy0), 1);
    applyStimulus(1, 1, 8, 0, 1, 9, int'(LAT_ALU), 0, 0, 0);
    checkOutput("div consumer stall", last_stall0, 1);
    applyStimulus(1, 0, 0, 0, 1, 9, 15, 0, 0, 0);
    checkOutput("div structural stall", last_stall0, 1);
    applyStimulus(1, 1, 8, 0, 1, 9, int'(LAT_ALU), 0, 1, 8);
    checkOutput("div done-cycle stall", last_stall0, 1);
    applyStimulus(1, 1, 8, 0, 1, 9, int'(LAT_ALU), 0, 0, 0);
    checkOutput("div consumer go", last_stall0, 0);
    checkOutput("div busy cleared", int'(long_busy0), 0);
    nop(4);

    // Taken branch overrides a load-use stall and the squashed add writes nothing.
    applyStimulus(1, 0, 0, 0, 1, 5, int'(LAT_LOAD), 0, 0, 0);
    applyStimulus(1, 1, 5, 0, 1, 6, 2, 1, 0, 0);
    checkOutput("branch stall", last_stall0, 0);
    checkOutput("branch flush_if_id", last_fifd0, 1);
    checkOutput("branch flush_id_ex", last_fide0, 1);
    checkOutput("branch perf_flush", int'(perf_flush0), 1);
    applyStimulus(1, 1, 6, 0, 0, 0, int'(LAT_ALU), 0, 0, 0);
    checkOutput("branch no cnt update", last_stall0, 0);
    nop(2);

    // Stray completion is a sticky error.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    nop(2);
    checkOutput("long_err sticky", int'(long_err0), 1);

    // Hold a consumer of an outstanding divide long enough to saturate the 4-bit counter.
    applyStimulus(1, 0, 0, 0, 1, 10, 15, 0, 0, 0);
    repeat (20) applyStimulus(1, 1, 10, 0, 0, 0, int'(LAT_ALU), 0, 0, 0);
    checkOutput("perf_stall saturated", int'(perf_stall1), 15);
    applyStimulus(1, 1, 10, 0, 0, 0, int'(LAT_ALU), 0, 0, 0);
    checkOutput("perf_stall held", int'(perf_stall1), 15);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 10);
    nop(2);

    // Reset in the middle of a divide clears everything.
    applyStimulus(1, 0, 0, 0, 1, 11, 15, 0, 0, 0);
    id_valid = 1'b1; id_src_valid = 2'b01; id_src = {5'd0, 5'd11}; id_lat = LAT_ALU;
    id_reg_write = 1'b0; long_done = 1'b0;
    reset = 1'b0;
    #2;
    checkOutput("midreset long_busy", int'(long_busy0), 0);
    checkOutput("midreset stall_pc", int'(stall_pc0), 0);
    checkOutput("midreset flush_id_ex", int'(flush_id_ex0), 0);
    checkOutput("midreset long_err", int'(long_err0), 0);
    checkOutput("midreset perf_stall", int'(perf_stall0), 0);
    checkOutput("midreset perf_flush1", int'(perf_flush1), 0);
    @(posedge clk);
    @(negedge clk);
    resetModel();
    reset = 1'b1;

    // Random traffic concentrated on a few registers to provoke hazards.
    repeat (600) begin
      int lat = ($urandom_range(0, 6) == 0) ? 15 : int'($urandom_range(0, 4));
      int lrd = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) != 0) begin
        for (int r = 1; r < 10; r++) if (pend[0][r]) lrd = r;
      end
      applyStimulus(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 9)), lat,
                    int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 5) == 0), lrd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
